// File: rtl/b16to4_seq_encoder_pkg.sv
// rtl/b16to4_seq_encoder_pkg.sv - shared widths, state codes and bit helpers
package b16to4_seq_encoder_pkg;

    localparam int VEC_W  = 16;
    localparam int CODE_W = 4;

    // Two-state controller: waiting for a vector, or emitting its codes
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    // Clear the lowest set bit of a vector
    function automatic logic [VEC_W-1:0] clear_lowest(input logic [VEC_W-1:0] v);
        return v & (v - 16'd1);
    endfunction

endpackage

// File: rtl/b16to4_seq_encoder_if.sv
// rtl/b16to4_seq_encoder_if.sv - vector-in / code-out handshake bundle
import b16to4_seq_encoder_pkg::*;

interface b16to4_seq_encoder_if;
    logic [VEC_W-1:0]  z15_z0;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] x3_x0;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    // Encoder side
    modport slave (
        input  z15_z0, in_valid, out_ready,
        output in_ready, x3_x0, out_valid, out_last
    );

    // Producer/consumer side
    modport master (
        output z15_z0, in_valid, out_ready,
        input  in_ready, x3_x0, out_valid, out_last
    );
endinterface

// File: rtl/b16to4_prio_encoder.sv
// rtl/b16to4_prio_encoder.sv - lowest-set-bit index with any/single flags
import b16to4_seq_encoder_pkg::*;

module b16to4_prio_encoder (
    input  logic [VEC_W-1:0]  vec,
    output logic [CODE_W-1:0] index,
    output logic              any,
    output logic              single
);

    // Scan from the top so the lowest set bit is the last one to win
    always_comb begin
        index = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = CODE_W'(i);
            end
        end
    end

    assign any    = |vec;
    assign single = any && (clear_lowest(vec) == '0);

endmodule

// File: rtl/b16to4_seq_encoder.sv
// rtl/b16to4_seq_encoder.sv - serialises a multi-hot vector into bit-index codes
import b16to4_seq_encoder_pkg::*;

module b16to4_seq_encoder (
    input  logic               clock,
    input  logic               reset_,
    b16to4_seq_encoder_if.slave bus
);

    logic [0:0]        state;
    logic [VEC_W-1:0]  pending;
    logic [CODE_W-1:0] low_idx;
    logic              any;
    logic              single;
    logic              take;
    logic              accept;

    b16to4_prio_encoder u_prio (
        .vec    (pending),
        .index  (low_idx),
        .any    (any),
        .single (single)
    );

    // Output side is a pure function of the registers; code forced to 0 when idle
    assign bus.out_valid = (state == S_SCAN) && any;
    assign bus.x3_x0     = bus.out_valid ? low_idx : '0;
    assign bus.out_last  = bus.out_valid && single;
    assign take          = bus.out_valid && bus.out_ready;

    // Ready in IDLE, or when the final code leaves this cycle so vectors run without a bubble
    assign bus.in_ready  = (state == S_IDLE) || (take && bus.out_last);
    assign accept        = bus.in_valid && bus.in_ready;

    // State and pending register: a new vector overrides the draining one, zero vectors are dropped
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state   <= S_IDLE;
            pending <= '0;
        end else if (accept) begin
            pending <= bus.z15_z0;
            state   <= (bus.z15_z0 != '0) ? S_SCAN : S_IDLE;
        end else if (take) begin
            pending <= clear_lowest(pending);
            if (bus.out_last) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_b16to4_seq_encoder.sv
// tb/tb_b16to4_seq_encoder.sv - self-checking bench with queue-based reference model
module tb_b16to4_seq_encoder;

    logic clock;
    logic reset_;
    int   n_checks;
    int   n_fails;
    int   q[$];
    bit   prev_valid;
    bit   prev_acc;

    b16to4_seq_encoder_if bus ();

    b16to4_seq_encoder dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the codes still owed for the current vector, in ascending order
    always @(posedge clock or negedge reset_) begin
        bit tk;
        bit rdy;
        if (!reset_) begin
            q.delete();
        end else begin
            tk  = (q.size() > 0) && bus.out_ready;
            rdy = (q.size() == 0) || (tk && q.size() == 1);
            if (tk) void'(q.pop_front());
            if (bus.in_valid && rdy) begin
                q.delete();
                for (int i = 0; i < 16; i++)
                    if (bus.z15_z0[i]) q.push_back(i);
            end
        end
    end

    // Every cycle, the DUT outputs must match what the owed-code list implies
    always @(negedge clock) begin
        int ev;
        int ex;
        int el;
        int er;
        ev = (q.size() > 0);
        ex = ev ? q[0] : 0;
        el = (q.size() == 1);
        er = (q.size() == 0) || (bus.out_ready && q.size() == 1);
        chk("out_valid", int'(bus.out_valid), ev);
        chk("x3_x0", int'(bus.x3_x0), ex);
        chk("out_last", int'(bus.out_last), el);
        chk("in_ready", int'(bus.in_ready), er);
    end

    task automatic drive(input bit iv, input logic [15:0] z, input bit ordy);
        @(posedge clock);
        #1;
        bus.in_valid  = iv;
        bus.z15_z0    = z;
        bus.out_ready = ordy;
        @(negedge clock);
    endtask

    initial begin
        int exp_seq [4];
        logic [15:0] z;
        n_checks = 0;
        n_fails  = 0;
        reset_        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.z15_z0    = '0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_code", int'(bus.x3_x0), 0);
        chk("rst_last", int'(bus.out_last), 0);
        chk("rst_ready", int'(bus.in_ready), 1);
        #3 reset_ = 1'b1;

        // Single-bit vector
        drive(1, 16'h0001, 1);
        drive(0, 16'h0000, 1);
        chk("t1_valid", int'(bus.out_valid), 1);
        chk("t1_code", int'(bus.x3_x0), 0);
        chk("t1_last", int'(bus.out_last), 1);
        drive(0, 16'h0000, 1);
        chk("t1_done_valid", int'(bus.out_valid), 0);
        chk("t1_done_ready", int'(bus.in_ready), 1);

        // Four spread bits
        exp_seq = '{0, 5, 10, 15};
        drive(1, 16'h8421, 1);
        for (int k = 0; k < 4; k++) begin
            drive(0, 16'h0000, 1);
            if (k == 0) begin
                chk("model_len", q.size(), 4);
                chk("model_tail", q[3], 15);
            end
            chk("t2_code", int'(bus.x3_x0), exp_seq[k]);
            chk("t2_last", int'(bus.out_last), (k == 3) ? 1 : 0);
            chk("t2_valid", int'(bus.out_valid), 1);
        end
        drive(0, 16'h0000, 1);
        chk("t2_done", int'(bus.out_valid), 0);

        // Consumer stall
        drive(1, 16'h0006, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 16'h0000, 0);
            chk("t3_hold_code", int'(bus.x3_x0), 1);
            chk("t3_hold_valid", int'(bus.out_valid), 1);
            chk("t3_hold_last", int'(bus.out_last), 0);
        end
        drive(0, 16'h0000, 1);
        chk("t3_code0", int'(bus.x3_x0), 1);
        drive(0, 16'h0000, 1);
        chk("t3_code1", int'(bus.x3_x0), 2);
        chk("t3_last", int'(bus.out_last), 1);
        drive(0, 16'h0000, 1);
        chk("t3_done", int'(bus.out_valid), 0);

        // Zero vector is swallowed
        for (int k = 0; k < 3; k++) begin
            drive(1, 16'h0000, 1);
            chk("t4_valid", int'(bus.out_valid), 0);
            chk("t4_ready", int'(bus.in_ready), 1);
        end

        // Back-to-back vectors
        drive(1, 16'h0003, 1);
        drive(1, 16'h8000, 1);
        chk("t5_code0", int'(bus.x3_x0), 0);
        chk("t5_ready0", int'(bus.in_ready), 0);
        drive(1, 16'h8000, 1);
        chk("t5_code1", int'(bus.x3_x0), 1);
        chk("t5_ready1", int'(bus.in_ready), 1);
        drive(0, 16'h0000, 1);
        chk("t5_code2", int'(bus.x3_x0), 15);
        chk("t5_last2", int'(bus.out_last), 1);
        drive(0, 16'h0000, 1);
        chk("t5_done", int'(bus.out_valid), 0);

        // Reset in the middle of a long vector
        drive(1, 16'hFFFF, 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 16'h0000, 1);
            chk("t6_code", int'(bus.x3_x0), k);
        end
        drive(0, 16'h0000, 0);
        chk("t6_pre_code", int'(bus.x3_x0), 5);
        #1 reset_ = 1'b0;
        #1;
        chk("t6_async_valid", int'(bus.out_valid), 0);
        chk("t6_async_code", int'(bus.x3_x0), 0);
        chk("t6_async_ready", int'(bus.in_ready), 1);
        @(posedge clock);
        #3 reset_ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 16'h0000, 1);
            chk("t6_after_valid", int'(bus.out_valid), 0);
            chk("t6_after_ready", int'(bus.in_ready), 1);
        end

        // Random traffic; the producer holds a vector until it is taken
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
        z = '0;
        for (int n = 0; n < 400; n++) begin
            bit iv;
            if (prev_valid && !prev_acc) begin
                iv = 1'b1;
            end else begin
                iv = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 3))
                    0: z = '0;
                    1: z = 16'(1) << $urandom_range(0, 15);
                    2: z = 16'($urandom);
                    default: z = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
                endcase
            end
            drive(iv, z, ($urandom_range(0, 3) != 0));
            prev_valid = iv;
            prev_acc   = iv && ((q.size() == 0) || (bus.out_ready && q.size() == 1));
        end

        drive(0, 16'h0000, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
